// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM state encoding, IR field positions, reset PC.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_pkg;

  // Fetch FSM states; S_FAULT is reachable only when the memory timeout is built in
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } fetch_state_e;

  // Instruction word layout: opcode in the top nibble, immediate in the low 12 bits
  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 12;
  localparam int IMM_W      = 12;

  // Address of the first fetch after reset
  localparam logic [15:0] RESET_PC = 16'h0000;

endpackage

// File: rtl/fetch_timeout_counter.sv
// Wait-cycle counter for an outstanding fetch; tc flags the cycle in which the limit is reached.
// Latency: tc is combinational from the registered count and the enable/clear inputs.
// Backpressure: none; the caller decides what to do with tc.
module fetch_timeout_counter #(
  parameter int unsigned TERMINAL = 255
) (
  input  logic CLK,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int CNT_W = (TERMINAL < 2) ? 1 : $clog2(TERMINAL + 1);

  logic [CNT_W-1:0] count;

  // Count enabled wait cycles; clear wins so a fresh request always starts from zero
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // The cycle that would make the count equal TERMINAL is the terminal cycle
  assign tc = enable && !clear && (count == CNT_W'(TERMINAL - 1));

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: holds the PC, fetches one word per req/ack handshake into the IR, supports redirects.
// Latency: ir_valid rises 1 cycle after mem_ack; best case 1 instruction per 2 cycles.
// Backpressure: IR held in S_HOLD until ir_ready; optional FETCH_TIMEOUT_EN adds a sticky memory-timeout fault.
module instr_fetch_unit #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 16,
  parameter int IMM_W          = 12,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              CLK,
  input  logic              Reset,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [3:0]        opcode,
  output logic [IMM_W-1:0]  imm,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              fetch_fault
);

  import fetch_pkg::*;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] ir;
  logic              take;
  logic              timeout_hit;

  // An ack only counts when no redirect is competing for the same cycle
  assign take = (state == S_REQ) && mem_ack && !redirect;

  // Next-state logic; redirect overrides everything except the fault trap
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = S_REQ;
      S_REQ: begin
        if (mem_ack)          state_nxt = S_HOLD;
        else if (timeout_hit) state_nxt = S_FAULT;
      end
      S_HOLD:  if (ir_ready) state_nxt = S_REQ;
      S_FAULT: state_nxt = S_FAULT;
      default: state_nxt = S_IDLE;
    endcase
    if (redirect && (state != S_FAULT)) state_nxt = S_REQ;
  end

  // State register
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // PC: redirect loads the target, an accepted ack advances (wrapping at the top of memory)
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      pc <= ADDR_W'(RESET_PC);
    end else if (redirect && (state != S_FAULT)) begin
      pc <= redirect_addr;
    end else if (take) begin
      pc <= pc + 1'b1;
    end
  end

  // IR and its fetch address change only on an accepted ack, so they stay stable while held
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      ir    <= '0;
      ir_pc <= '0;
    end else if (take) begin
      ir    <= mem_rdata;
      ir_pc <= pc;
    end
  end

  assign mem_req  = (state == S_REQ);
  assign mem_addr = pc;
  assign ir_valid = (state == S_HOLD);
  assign opcode   = ir[OPCODE_MSB:OPCODE_LSB];
  assign imm      = ir[IMM_W-1:0];

`ifdef FETCH_TIMEOUT_EN
  logic to_clear;
  logic to_enable;

  // Counter restarts whenever we are not waiting, or the wait ends by ack or redirect
  assign to_clear  = (state != S_REQ) || mem_ack || redirect;
  assign to_enable = (state == S_REQ);

  fetch_timeout_counter #(
    .TERMINAL (TIMEOUT_CYCLES)
  ) u_timeout (
    .CLK    (CLK),
    .Reset  (Reset),
    .clear  (to_clear),
    .enable (to_enable),
    .tc     (timeout_hit)
  );

  // Sticky fault flag; only reset clears it
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset)                                  fetch_fault <= 1'b0;
    else if ((state == S_REQ) && timeout_hit)   fetch_fault <= 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
  // Without the timeout the fault output is inert; the parameter is kept for a uniform interface
  assign fetch_fault = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

endmodule
